truth_table_eval: RTL and testbench



---
 rtl/truth_table_eval_pkg.sv | 19 +
 rtl/truth_table_eval_if.sv | 25 ++
 rtl/truth_table_eval_stability_filter.sv | 52 +++++
 rtl/truth_table_eval.sv | 105 ++++++++++
 tb/tb_truth_table_eval.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/truth_table_eval_pkg.sv
// Shared types and sizing rules for the reloadable truth-table gate.
// Everything here is pure elaboration-time: no logic, no latency, no flow control.
package truth_table_pkg;

  typedef enum logic {
    SETTLING = 1'b0,
    STABLE   = 1'b1
  } state_e;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

  // Settle counter width is max(1, clog2(settle)); it counts 0..settle-1.
  function automatic int cnt_width(input int settle);
    return (settle <= 2) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/truth_table_eval_if.sv
// Gate-side bus: input vector, table-load handshake and settled output.
// master drives inputs and table offers; slave (the gate) answers with ready and outputs.
interface truth_table_eval_if
  import truth_table_pkg::*;
#(
  parameter int N_IN = 3
);
  logic [N_IN-1:0]           in;
  logic                      cfg_valid;
  logic [tt_width(N_IN)-1:0] cfg_data;
  logic                      cfg_ready;
  logic                      out;
  logic                      out_valid;
  logic                      changed;

  modport master (
    output in, cfg_valid, cfg_data,
    input  cfg_ready, out, out_valid, changed
  );

  modport slave (
    input  in, cfg_valid, cfg_data,
    output cfg_ready, out, out_valid, changed
  );
endinterface

// File: rtl/truth_table_eval_stability_filter.sv
// Input settling filter: flags the edge at which the input has matched its previous sample SETTLE times in a row.
// Latency: settle asserts SETTLE edges after a new value is first sampled; restart/hold come from the owner, no backpressure.
module stability_filter
  import truth_table_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in,
  input  logic            hold,
  input  logic            restart,
  output logic [N_IN-1:0] in_q,
  output logic            match,
  output logic            settle
);

  localparam int                 CNT_W    = cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic [N_IN-1:0]  in_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    in_d   = in;
    cnt_d  = cnt_q;
    match  = (in == in_q);
    settle = 1'b0;

    // Any disturbance, or a table reload, restarts the stability window.
    if (!match || restart) begin
      cnt_d = '0;
    end else if (!hold && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    settle = match && !hold && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      cnt_q <= '0;
    end else begin
      in_q  <= in_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_eval.sv
// N-input gate evaluated from a reloadable truth table, with output gated by an input settling filter.
// Latency: SETTLE edges from new input or table load to out/out_valid; table loads are taken only while STABLE.
module truth_table_eval
  import truth_table_pkg::*;
#(
  parameter int                         N_IN       = 3,
  parameter int                         SETTLE     = 4,
  parameter logic [tt_width(N_IN)-1:0] DEFAULT_TT = 8'hA0
) (
  input  logic               clk,
  input  logic               rst_n,
  truth_table_eval_if.slave  bus
);

  localparam int TT_W = tt_width(N_IN);

  state_e            state_q;
  state_e            state_d;
  logic [TT_W-1:0]   tt_q;
  logic [TT_W-1:0]   tt_d;
  logic              out_q;
  logic              out_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic              changed_q;
  logic              changed_d;

  logic [N_IN-1:0]   in_q;
  logic              match;
  logic              settle;
  logic              cfg_accept;
  logic              tt_bit;

  stability_filter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (bus.in),
    .hold    (state_q == STABLE),
    .restart (cfg_accept),
    .in_q    (in_q),
    .match   (match),
    .settle  (settle)
  );

  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    changed_d   = 1'b0;
    cfg_accept  = bus.cfg_valid && (state_q == STABLE);
    tt_bit      = tt_q[in_q];

    if (cfg_accept) begin
      tt_d = bus.cfg_data;
    end

    case (state_q)
      SETTLING: begin
        if (settle) begin
          state_d     = STABLE;
          out_d       = tt_bit;
          out_valid_d = 1'b1;
          changed_d   = (tt_bit != out_q);
        end
      end
      STABLE: begin
        // A reload and an input change both just reopen the window; out keeps its last settled value.
        if (!match || cfg_accept) begin
          state_d     = SETTLING;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = SETTLING;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SETTLING;
      tt_q        <= DEFAULT_TT;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      changed_q   <= changed_d;
    end
  end

  assign bus.cfg_ready = (state_q == STABLE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.changed   = changed_q;

endmodule

// File: tb/tb_truth_table_eval.sv
// Scoreboard bench for truth_table_eval: directed scenarios then random input/table traffic.
module tb_truth_table_eval;
  import truth_table_pkg::*;

  localparam int         N_IN   = 3;
  localparam int         SETTLE = 4;
  localparam int         TW     = 8;
  localparam logic [7:0] DEF_TT = 8'hA0;

  typedef struct packed {
    logic rdy;
    logic vld;
    logic out;
    logic chg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_eval_if #(.N_IN(N_IN)) bus();

  truth_table_eval #(
    .N_IN       (N_IN),
    .SETTLE     (SETTLE),
    .DEFAULT_TT (DEF_TT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference: the gate is "stable" once SETTLE edges have passed since the last
  // input change or table load; the edge where that age reaches SETTLE refreshes out.
  logic [N_IN-1:0] m_prev;
  int              m_age;
  logic [TW-1:0]   m_tt;
  logic            m_out;

  function automatic void model_reset();
    m_prev = '0;
    m_age  = 0;
    m_tt   = DEF_TT;
    m_out  = 1'b0;
  endfunction

  task automatic step(input logic [N_IN-1:0] i, input logic cv, input logic [TW-1:0] cd,
                      output logic acc);
    exp_t e;
    logic settle_now;
    @(negedge clk);
    bus.in        = i;
    bus.cfg_valid = cv;
    bus.cfg_data  = cd;
    acc        = cv && (m_age >= SETTLE);
    settle_now = 1'b0;
    if ((i != m_prev) || acc) begin
      m_age = 0;
    end else if (m_age < SETTLE) begin
      m_age      = m_age + 1;
      settle_now = (m_age == SETTLE);
    end
    e.chg = 1'b0;
    if (settle_now) begin
      e.chg = (m_tt[i] != m_out);
      m_out = m_tt[i];
    end
    if (acc) m_tt = cd;
    m_prev = i;
    e.rdy  = (m_age >= SETTLE);
    e.vld  = (m_age >= SETTLE);
    e.out  = m_out;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [N_IN-1:0] i, input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(i, 1'b0, '0, acc);
  endtask

  // The offerer holds cfg_valid until the gate takes the table (bounded).
  task automatic offer(input logic [N_IN-1:0] i, input logic [TW-1:0] cd, input int budget);
    logic acc;
    for (int k = 0; k < budget; k++) begin
      step(i, 1'b1, cd, acc);
      if (acc) break;
    end
  endtask

  task automatic check_reset(input string name);
    exp_t got;
    got = {bus.cfg_ready, bus.out_valid, bus.out, bus.changed};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL %s: got rdy=%b vld=%b out=%b chg=%b, expected all 0",
               name, got.rdy, got.vld, got.out, got.chg);
    end
  endtask

  // Monitor: one expected record per edge while out of reset.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
        got = {bus.cfg_ready, bus.out_valid, bus.out, bus.changed};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty cycle %0d: DUT output with no expected record", cyc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL sb cycle %0d: got rdy=%b vld=%b out=%b chg=%b, expected rdy=%b vld=%b out=%b chg=%b",
                     cyc, got.rdy, got.vld, got.out, got.chg, e.rdy, e.vld, e.out, e.chg);
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    bus.in        = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    model_reset();
    #12;
    check_reset("reset_state");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Settle to 101 then 110, then 111 ahead of a short glitch.
    drive(3'b101, 6);
    drive(3'b110, 6);
    drive(3'b111, 6);
    drive(3'b011, 2);
    drive(3'b111, 8);

    // Table load while stable at 000.
    drive(3'b000, 6);
    offer(3'b000, 8'h01, 20);
    drive(3'b000, 6);

    // Offer during settling: held until the first stable cycle.
    drive(3'b010, 1);
    offer(3'b010, 8'h04, 20);
    drive(3'b010, 6);

    // Load and input change on the same edge.
    step(3'b110, 1'b1, 8'h40, acc);
    drive(3'b110, 6);

    // Reset while settling after a load.
    offer(3'b110, 8'hFF, 20);
    drive(3'b110, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid_settle");
    bus.cfg_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    drive(3'b000, 6);
    drive(3'b101, 6);

    // Random input holds and table offers.
    repeat (80) begin
      logic [N_IN-1:0] ri;
      ri = N_IN'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) offer(ri, TW'($urandom), 20);
      drive(ri, $urandom_range(1, 7));
    end

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
